uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receive front-end. It is the next generation of the fixed 8-bit receiver on the board-shield path. It synchronises and optionally inverts the raw line, majority-samples each bit and decodes configurable frame formats (data width, parity, stop bits). Received words go out through a valid/ready handshake with per-word error flags, so it can drop between the shield pins and any downstream consumer.

## Interface
- `CLK_HZ`, 66_000_000, system clock frequency.
- `BAUD_BPS`, 9600, line bit rate.
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame: 1 or 2.
- `RX_INVERT`, 0, 1 inverts the line after the synchroniser.
- `FIFO_DEPTH`, 8, power of two ≥2; used only with `UART_RX_FIFO_EN`.
- `clk`  in  1  system clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw asynchronous serial line; idle high after optional inversion.
- `data`  out  DATA_BITS  received word, LSB first on the line.
- `data_valid`  out  1  `data`, `parity_err` and `frame_err` are valid.
- `data_ready`  in  1  consumer accepts the word when high together with `data_valid`.
- `parity_err`  out  1  parity error on the presented word; always 0 when PARITY=0.
- `frame_err`  out  1  first (or second) stop bit sampled low on the presented word.
- `overrun`  out  1  sticky: a completed word was dropped.
- `clear_err`  in  1  synchronous clear of `overrun`.
- `busy`  out  1  receiver FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, then is XORed with RX_INVERT to give `rxs`.
- `CPB = round(CLK_HZ/BAUD_BPS)`. Counter width is `$clog2(CPB)`. `HALF = CPB/2`.
- Each bit is sampled as the 2-of-3 majority of `rxs` at counter values HALF-1, HALF and HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE → START when `rxs`=0. The counter clears.
- START: if the majority sample is 1, this is a false start and the FSM returns to IDLE. Otherwise, at CPB-1 the FSM goes to DATA.
- DATA: DATA_BITS samples are shifted in LSB first. Then go to PARITY if PARITY≠0, else go to STOP.
- PARITY: compute the expected bit (odd: XOR of data inverted; even: XOR of data). A mismatch latches the per-word parity error.
- STOP: sample STOP_BITS bits. Any low sample sets the per-word frame error.
  - The word completes at the mid-sample of the last stop bit.
  - The FSM then goes to IDLE if that sample is 1, else to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A break condition therefore yields exactly one word.
- Word completion pushes {data, parity_err, frame_err} into the output buffer.
- Output buffer without FIFO: a single holding register.
  - If it is occupied and not popped in the same cycle, the new word is dropped and `overrun` is set.
  - The held word is never overwritten.
- Output buffer with FIFO: see Configuration.
- Handshake: `data`/flags stay stable while `data_valid && !data_ready`. A pop occurs on `data_valid && data_ready`.
- A pop and a push in the same cycle are both accepted; nothing is dropped.
- If `clear_err` and a new overrun occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, buffer empty.
  - `data`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - Synchroniser flops reset to the idle level.

## Timing
- Input latency: 2 cycles of synchroniser.
- `data_valid` rises 1 cycle after the final stop-bit mid-sample (counter = HALF+1).
- Start edge to `data_valid`: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 1)·CPB + HALF + 4 cycles, ±1 cycle of edge phase.
- `busy` is high from the cycle after the start edge is seen until the cycle the FSM re-enters IDLE.
- The next start bit is accepted in the first IDLE cycle. Back-to-back frames at full baud must be received without loss.

## Configuration
- `UART_RX_FIFO_EN`, defined: the output buffer is a show-ahead FIFO of FIFO_DEPTH entries of width DATA_BITS+2.
  - `data_valid` = !empty.
  - A push when full (with no pop in the same cycle) drops the word and sets `overrun`.
- `UART_RX_FIFO_EN`, undefined: the output buffer is the single holding register; FIFO_DEPTH is ignored.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - parity constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the function `clks_per_bit(clk_hz, baud)`.
- Sub-module `uart_rx_fifo` (parametrised width/depth, show-ahead, full/empty) is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- 8N1 at 9600 baud, frame 0xA5, `data_ready`=1 → one `data_valid` pulse with `data`=0xA5, `parity_err`=0, `frame_err`=0.
- DATA_BITS=7, PARITY=2, frame 0x35 sent with the parity bit flipped → `data`=0x35, `parity_err`=1. Correct parity → `parity_err`=0.
- Low glitch of CPB/4 cycles on an idle line → no word, `busy` returns to 0 within HALF+3 cycles.
- Stop bit forced low, then line held low for 3 bit-times → exactly one word with `frame_err`=1. A following valid 0x3C frame is received cleanly.
- No FIFO, `data_ready`=0, frames 0x11 then 0x22 → `data` stays 0x11, `overrun`=1. `clear_err` clears `overrun`.
- `UART_RX_FIFO_EN`, depth 8, `data_ready`=0, 9 frames 0x01..0x09 → `overrun`=1. Draining yields 0x01..0x08 in order. Asserting `rst` mid-frame during the drain empties the buffer and zeroes all outputs immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Rounded clock cycles per line bit.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO holding received words; used when UART_RX_FIFO_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 2-of-3 majority sampling, frame decode, valid/ready output.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 66_000_000,
  parameter int unsigned BAUD_BPS   = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned RX_INVERT  = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clear_err,
  output logic                 busy
);

  localparam int unsigned CPB  = clks_per_bit(CLK_HZ, BAUD_BPS);
  localparam int unsigned CW   = $clog2(CPB);
  localparam int unsigned HALF = CPB / 2;
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_MID  = CW'(HALF + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic          INV    = (RX_INVERT != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_param: illegal DATA_BITS, STOP_BITS or FIFO_DEPTH");
  end

  uart_rx_state_t       state;
  logic                 sync1, sync2, rxs;
  logic [CW-1:0]        cnt;
  logic                 s0, s1, maj, mid, last;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 push, pop, accept;

  // Reset to the raw idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= ~INV;
      sync2 <= ~INV;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rxs  = sync2 ^ INV;
  assign maj  = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign mid  = (cnt == C_MID);
  assign last = (cnt == C_LAST);
  assign push = (state == ST_STOP) && mid && (stop_idx == 1'(STOP_BITS - 1));
  assign pop  = data_valid && data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
      if (cnt == C_S0) s0 <= rxs;
      if (cnt == C_S1) s1 <= rxs;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= ST_START;
            busy  <= 1'b1;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        ST_START: begin
          if (mid && maj) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (last) begin
            cnt <= '0;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (mid) perr <= maj ^ ((PARITY == PAR_ODD) ? ~(^shreg) : (^shreg));
          if (last) begin
            cnt   <= '0;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (mid) begin
            if (!maj) ferr <= 1'b1;
            if (push) begin
              state <= maj ? ST_IDLE : ST_WAIT_HIGH;
              busy  <= !maj;
            end
          end else if (last) begin
            cnt      <= '0;
            stop_idx <= 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rxs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS+1:0] fifo_dout;

  assign accept     = push && (!fifo_full || pop);
  assign data_valid = !fifo_empty;
  assign {data, parity_err, frame_err} = fifo_dout;

  uart_rx_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .din  ({shreg, perr, ferr | ~maj}),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );
`else
  assign accept = push && (!data_valid || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (accept) begin
      data       <= shreg;
      parity_err <= perr;
      frame_err  <= ferr | ~maj;
      data_valid <= 1'b1;
    end else if (pop) begin
      data_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   overrun <= 1'b0;
    else if (push && !accept)  overrun <= 1'b1;
    else if (clear_err)        overrun <= 1'b0;
  end

endmodule
